// File: rtl/packet_rx_unit.sv
// NoC receive endpoint: checks per-packet sequence numbers 1,2,3.. and posts one result record per packet.
// Record valid the cycle after the closing edge; rx_ready drops while a record awaits pkt_ack.
module packet_rx_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flit_valid,
   input  logic [8:0]  flit_data,
   output logic        rx_ready,
   output logic        pkt_valid,
   input  logic        pkt_ack,
   output logic [7:0]  pkt_len,
   output logic        pkt_seq_err,
   output logic        pkt_timeout,
   output logic [15:0] pkt_count,
   output logic [7:0]  err_count,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

   localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

   state_t     state, state_nx;
   logic [7:0] beat_cnt, beat_nx;
   logic [7:0] exp_seq, exp_nx;
   logic [7:0] idle_cnt, idle_nx;
   logic       err_flag, err_nx;

   logic       close, close_err, close_to;
   logic [7:0] close_len;
   logic       accept, tlast, seq_bad;
   logic [7:0] seq;

   // Transmitter counter skips 0, so 255 is followed by 1.
   function automatic logic [7:0] next_seq(input logic [7:0] s);
      return (s == 8'hFF) ? 8'h01 : s + 8'h01;
   endfunction

   assign rx_ready  = (state != HOLD);
   assign busy      = (state != IDLE);
   assign pkt_valid = (state == HOLD);

   assign accept  = flit_valid && rx_ready;
   assign tlast   = flit_data[8];
   assign seq     = flit_data[7:0];
   assign seq_bad = (seq != exp_seq);

   always_comb begin
      state_nx  = state;
      beat_nx   = beat_cnt;
      exp_nx    = exp_seq;
      idle_nx   = idle_cnt;
      err_nx    = err_flag;
      close     = 1'b0;
      close_len = beat_cnt;
      close_err = err_flag;
      close_to  = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               beat_nx   = 8'd1;
               exp_nx    = next_seq(seq);
               idle_nx   = 8'd0;
               err_nx    = (seq != 8'd1);
               close_err = (seq != 8'd1);
               close_len = 8'd1;
               if (tlast) begin
                  close    = 1'b1;
                  state_nx = HOLD;
               end else begin
                  state_nx = RECV;
               end
            end
         end
         RECV: begin
            if (accept) begin
               idle_nx = 8'd0;
               exp_nx  = next_seq(seq);
               if (beat_cnt == 8'hFF) begin
                  // Length overflow: the flit is consumed and the packet is cut at 255.
                  err_nx    = 1'b1;
                  close     = 1'b1;
                  close_len = 8'hFF;
                  close_err = 1'b1;
               end else begin
                  beat_nx   = beat_cnt + 8'd1;
                  err_nx    = err_flag | seq_bad;
                  close_err = err_flag | seq_bad;
                  close_len = beat_cnt + 8'd1;
                  close     = tlast;
               end
            end else begin
               idle_nx = idle_cnt + 8'd1;
               if (idle_cnt == IDLE_LIMIT) begin
                  close    = 1'b1;
                  close_to = 1'b1;
               end
            end
            if (close) state_nx = HOLD;
         end
         HOLD: begin
            if (pkt_ack) begin
               state_nx = IDLE;
               beat_nx  = 8'd0;
               exp_nx   = 8'd0;
               idle_nx  = 8'd0;
               err_nx   = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         beat_cnt    <= 8'd0;
         exp_seq     <= 8'd0;
         idle_cnt    <= 8'd0;
         err_flag    <= 1'b0;
         pkt_len     <= 8'd0;
         pkt_seq_err <= 1'b0;
         pkt_timeout <= 1'b0;
         pkt_count   <= 16'd0;
         err_count   <= 8'd0;
      end else begin
         state    <= state_nx;
         beat_cnt <= beat_nx;
         exp_seq  <= exp_nx;
         idle_cnt <= idle_nx;
         err_flag <= err_nx;
         if (close) begin
            pkt_len     <= close_len;
            pkt_seq_err <= close_err;
            pkt_timeout <= close_to;
            pkt_count   <= pkt_count + 16'd1;
            if ((close_err || close_to) && (err_count != 8'hFF))
               err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: doc/packet_rx_unit.md
# packet_rx_unit

Receive-side endpoint for the processing-unit NoC link. It consumes 9-bit flits `{tlast, seq[7:0]}` delivered by the local router and checks that each packet's sequence numbers run 1, 2, 3… up to the flit marked tlast. It reports one result record per packet (length, sequence error, timeout) to the local processor over a valid/ack handshake, and keeps running packet and error counters.

## Interface
- `TIMEOUT`, default 16: number of consecutive cycles without an accepted flit, inside a packet, that aborts the packet (legal range 2–255).
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `flit_valid`  in  1  router presents a flit on `flit_data`.
- `flit_data`  in  9  bit 8 = tlast; bits 7:0 = sequence number.
- `rx_ready`  out  1  block can accept a flit this cycle.
- `pkt_valid`  out  1  result record is valid and held stable.
- `pkt_ack`  in  1  processor consumes the result record.
- `pkt_len`  out  8  number of flits in the packet.
- `pkt_seq_err`  out  1  packet had a sequence mismatch or a length overflow.
- `pkt_timeout`  out  1  packet was aborted by timeout.
- `pkt_count`  out  16  total packets closed since reset; wraps.
- `err_count`  out  8  total packets closed with an error or timeout; saturates at 255.
- `busy`  out  1  a packet is in progress or a result is pending.

## Operation
- **Flit acceptance:** a flit is accepted when `flit_valid && rx_ready`. A flit offered while `rx_ready=0` is not consumed; the router holds it.
- **FSM states:** IDLE, RECV, HOLD.
- **Outputs by state:**
  - `rx_ready` = 1 in IDLE and RECV, 0 in HOLD.
  - `busy` = 1 in RECV and HOLD.
  - `pkt_valid` = 1 in HOLD only.
- **IDLE:**
  - The first accepted flit opens a packet: beat count = 1, expected sequence = 1.
  - If `seq != 1`, the packet error flag is set.
  - tlast=1 → go to HOLD with len 1. Otherwise → go to RECV.
- **RECV, on each accepted flit:**
  - Expected sequence = previous received `seq + 1`, with 255 wrapping to 1 (the transmitter counter never emits 0). Any mismatch sets the packet error flag, which is sticky for that packet.
  - The beat counter increments.
  - A flit arriving with the beat count already at 255 and tlast=0 sets the error flag, closes the packet with len 255, and goes to HOLD.
  - tlast=1 → go to HOLD; `pkt_len` = beat count including the tlast flit.
- **RECV, idle cycles:**
  - The idle counter increments on each cycle with no accepted flit and clears on any accepted flit.
  - When the idle counter reaches `TIMEOUT`, go to HOLD with `pkt_timeout=1` and `pkt_len` = beats received so far.
- **Entering HOLD:**
  - `pkt_len`, `pkt_seq_err` and `pkt_timeout` are registered and held stable until ack.
  - `pkt_count` increments by 1.
  - `err_count` increments, saturating, if `pkt_seq_err` or `pkt_timeout` is set.
- **HOLD:** `pkt_ack=1` → go to IDLE on the next edge. `pkt_ack` in any other state is ignored.
- **Width rules:**
  - Sequence compare is 8-bit.
  - The idle counter is 8-bit.
  - `pkt_count` wraps 0xFFFF→0.
  - `err_count` saturates at 0xFF.

## Timing
- **Reset values:** state IDLE, `rx_ready=1`, `busy=0`, `pkt_valid=0`, `pkt_len=0`, `pkt_seq_err=0`, `pkt_timeout=0`, `pkt_count=0`, `err_count=0`. Internal beat, expected-sequence and idle counters are 0.
- **Reset mid-packet:** the partial packet is discarded and no counter is updated.
- **Latency:** `pkt_valid` rises on the edge that accepts the tlast flit, so it is visible in the following cycle.
- **Throughput:** one flit per cycle in RECV.
- **Handshake turnaround:**
  - `pkt_ack` is sampled at edge N; `pkt_valid` falls and `rx_ready` rises after edge N.
  - The earliest next flit is accepted at edge N+1.
  - Minimum gap between packets is 1 cycle plus the ack delay.
- **Timeout:** with `TIMEOUT=16`, the last accepted flit at edge E puts HOLD in effect after edge E+16.
- **Simultaneous events:**
  - A flit accepted on the same edge the timeout would fire takes priority; the counter clears and there is no timeout.
  - `flit_valid` with `pkt_ack` in HOLD: the flit is not accepted that cycle.
- **Output timing:** all outputs are registered or decoded from the state register; no combinational path from `flit_*` to `rx_ready`.

## Test plan
- **Nominal packet:** flits 0x001, 0x002, 0x003, 0x104 on consecutive cycles → `pkt_valid` the next cycle, `pkt_len=4`, `pkt_seq_err=0`, `pkt_timeout=0`, `pkt_count=1`; ack → IDLE and `rx_ready=1`.
- **Single-flit packet:** 0x101 → `pkt_len=1`, no error. A following 0x001, 0x102 after ack → `pkt_len=2`, `pkt_count=2`.
- **Sequence error:** 0x001, 0x003, 0x104 → `pkt_len=3`, `pkt_seq_err=1`, `err_count=1`. A packet starting with 0x002 also flags `pkt_seq_err`.
- **Timeout:** `TIMEOUT=16`, flits 0x001, 0x002, then `flit_valid=0` → `pkt_valid` 16 cycles after the last accept, `pkt_timeout=1`, `pkt_len=2`. Separately, a gap of 15 cycles then 0x103 → normal close, `pkt_len=3`.
- **Backpressure:** hold `pkt_ack=0` for 5 cycles in HOLD while driving `flit_valid=1` with 0x101 → `rx_ready=0` and the flit is not consumed. After ack, 0x101 is accepted one cycle later and the next `pkt_len=1`.
- **Length limit and reset:** 255 flits with seq 1..255 and tlast on the 255th → `pkt_len=255`, no error. A 256th flit without tlast → error flag, len 255. Asserting `reset` mid-packet → all outputs return to reset values and counters read 0.
